// File: rtl/ahb_dma_pkg.sv
// Shared types and constants for the AHB DMA burst scheduler.
// Holds the FSM state enum, HBURST codes, the command record and the burst encoder.
package ahb_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_RD_CMD,
    ST_RD_WAIT,
    ST_WR_CMD,
    ST_WR_WAIT
  } sched_st_e;

  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_INCR   = 3'b001;
  localparam logic [2:0] HB_INCR4  = 3'b011;
  localparam logic [2:0] HB_INCR8  = 3'b101;
  localparam logic [2:0] HB_INCR16 = 3'b111;

  localparam int unsigned BDY_BYTES    = 1024;
  localparam int          CMD_ADDR_MAX = 64;

  typedef struct packed {
    logic [CMD_ADDR_MAX-1:0] addr;
    logic                    write;
    logic [4:0]              beats;
    logic [2:0]              burst;
  } cmd_t;

  // Fixed-length codes are only legal when the burst start is aligned to its total span.
  function automatic logic [2:0] burst_enc(input logic [4:0] beats, input logic [9:0] addr_lo,
                                           input int unsigned sz);
    logic [9:0] span;
    logic [2:0] enc;
    span = 10'(beats) << sz;
    enc  = HB_INCR;
    if (beats == 5'd1) begin
      enc = HB_SINGLE;
    end else if ((addr_lo & (span - 10'd1)) == 10'd0) begin
      case (beats)
        5'd4:    enc = HB_INCR4;
        5'd8:    enc = HB_INCR8;
        5'd16:   enc = HB_INCR16;
        default: enc = HB_INCR;
      endcase
    end
    burst_enc = enc;
  endfunction

endpackage

// File: rtl/ahb_dma_burst_sched_chunk.sv
// Combinational chunk sizing: min(remaining, MAX_BEATS, 1 KB headroom of src and dst),
// plus the HBURST code for the read and the write burst of that chunk.
module ahb_chunk_calc
  import ahb_dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16,
  parameter int MAX_BEATS = 16,
  parameter int SIZE_LOG2 = 2
) (
  input  logic [LEN_WIDTH-1:0] rem,
  input  logic [9:0]           src_lo,
  input  logic [9:0]           dst_lo,
  output logic [4:0]           beats,
  output logic [2:0]           rd_burst,
  output logic [2:0]           wr_burst
);

  logic [10:0] bdy_src;
  logic [10:0] bdy_dst;
  logic [10:0] lim;

  always_comb begin
    bdy_src = (11'(BDY_BYTES) - {1'b0, src_lo}) >> SIZE_LOG2;
    bdy_dst = (11'(BDY_BYTES) - {1'b0, dst_lo}) >> SIZE_LOG2;
    lim     = 11'(MAX_BEATS);
    if (rem < LEN_WIDTH'(MAX_BEATS)) lim = 11'(rem);
    if (bdy_src < lim) lim = bdy_src;
    if (bdy_dst < lim) lim = bdy_dst;
    beats    = 5'(lim);
    rd_burst = burst_enc(beats, src_lo, SIZE_LOG2);
    wr_burst = burst_enc(beats, dst_lo, SIZE_LOG2);
  end

endmodule

// File: rtl/ahb_dma_burst_sched.sv
// Splits one DMA descriptor into alternating read/write burst commands for the AHB master PE.
//   state    | meaning
//   IDLE     | waiting for a descriptor
//   CALC     | sizing the next chunk
//   RD_CMD   | read burst offered to the PE
//   RD_WAIT  | read burst in flight
//   WR_CMD   | write burst offered to the PE
//   WR_WAIT  | write burst in flight, then advance or finish
module ahb_dma_burst_sched
  import ahb_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ADDR_WIDTH-1:0] desc_src,
  input  logic [ADDR_WIDTH-1:0] desc_dst,
  input  logic [LEN_WIDTH-1:0]  desc_len,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic                  cmd_write,
  output logic [4:0]            cmd_beats,
  output logic [2:0]            cmd_burst,
  output logic [2:0]            cmd_size,
  input  logic                  pe_done,
  input  logic                  pe_err,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int SZ = $clog2(DATA_WIDTH / 8);

  sched_st_e             st_q, st_d;
  logic [ADDR_WIDTH-1:0] src_q, dst_q, step;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [4:0]            chunk_q, calc_beats;
  logic [2:0]            rd_burst_q, wr_burst_q, calc_rd, calc_wr;
  logic                  abort_q, abort_d, done_q, done_d, err_q, err_d;
  logic                  desc_bad;
  cmd_t                  cmd;

  assign step     = ADDR_WIDTH'(chunk_q) << SZ;
  assign desc_bad = (desc_len == '0) || (desc_src[SZ-1:0] != '0) || (desc_dst[SZ-1:0] != '0);

  ahb_chunk_calc #(
    .LEN_WIDTH(LEN_WIDTH),
    .MAX_BEATS(MAX_BEATS),
    .SIZE_LOG2(SZ)
  ) u_calc (
    .rem     (rem_q),
    .src_lo  (src_q[9:0]),
    .dst_lo  (dst_q[9:0]),
    .beats   (calc_beats),
    .rd_burst(calc_rd),
    .wr_burst(calc_wr)
  );

  always_comb begin
    st_d    = st_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    abort_d = abort_q;
    case (st_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (desc_valid) begin
          if (desc_bad) err_d = 1'b1;
          else          st_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        if (abort) begin
          err_d = 1'b1;
          st_d  = ST_IDLE;
        end else begin
          st_d = ST_RD_CMD;
        end
      end
      ST_RD_CMD, ST_WR_CMD: begin
        // An abort arriving with the handshake is deferred until the burst completes.
        if (cmd_ready) begin
          abort_d = abort_q | abort;
          if (st_q == ST_RD_CMD) st_d = ST_RD_WAIT;
          else                   st_d = ST_WR_WAIT;
        end else if (abort) begin
          err_d = 1'b1;
          st_d  = ST_IDLE;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        abort_d = abort_q | abort;
        if (pe_err) begin
          err_d = 1'b1;
          st_d  = ST_IDLE;
        end else if (pe_done) begin
          if (abort_q || abort) begin
            err_d = 1'b1;
            st_d  = ST_IDLE;
          end else if (st_q == ST_RD_WAIT) begin
            st_d = ST_WR_CMD;
          end else if (rem_q == LEN_WIDTH'(chunk_q)) begin
            done_d = 1'b1;
            st_d   = ST_IDLE;
          end else begin
            st_d = ST_CALC;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      st_q       <= ST_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      chunk_q    <= '0;
      rd_burst_q <= '0;
      wr_burst_q <= '0;
      abort_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      st_q    <= st_d;
      abort_q <= abort_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (st_q == ST_IDLE && desc_valid && !desc_bad) begin
        src_q <= desc_src;
        dst_q <= desc_dst;
        rem_q <= desc_len;
      end
      if (st_q == ST_CALC) begin
        chunk_q    <= calc_beats;
        rd_burst_q <= calc_rd;
        wr_burst_q <= calc_wr;
      end
      if (st_q == ST_WR_WAIT && pe_done && !pe_err) begin
        src_q <= src_q + step;
        dst_q <= dst_q + step;
        rem_q <= rem_q - LEN_WIDTH'(chunk_q);
      end
    end
  end

  always_comb begin
    cmd = '0;
    if (st_q == ST_RD_CMD) begin
      cmd.addr  = CMD_ADDR_MAX'(src_q);
      cmd.beats = chunk_q;
      cmd.burst = rd_burst_q;
    end else if (st_q == ST_WR_CMD) begin
      cmd.addr  = CMD_ADDR_MAX'(dst_q);
      cmd.write = 1'b1;
      cmd.beats = chunk_q;
      cmd.burst = wr_burst_q;
    end
  end

  assign cmd_valid  = (st_q == ST_RD_CMD) || (st_q == ST_WR_CMD);
  assign cmd_addr   = ADDR_WIDTH'(cmd.addr);
  assign cmd_write  = cmd.write;
  assign cmd_beats  = cmd.beats;
  assign cmd_burst  = cmd.burst;
  assign cmd_size   = 3'(SZ);
  assign desc_ready = (st_q == ST_IDLE);
  assign busy       = (st_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ahb_dma_burst_sched.sv
// Directed bench for ahb_dma_burst_sched: the bench plays the descriptor source and the AHB PE.
module tb_ahb_dma_burst_sched;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [31:0] desc_src = '0;
  logic [31:0] desc_dst = '0;
  logic [15:0] desc_len = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [4:0]  cmd_beats;
  logic [2:0]  cmd_burst;
  logic [2:0]  cmd_size;
  logic        pe_done = 1'b0;
  logic        pe_err = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad = 0;

  ahb_dma_burst_sched dut (
    .hclk(hclk), .hresetn(hresetn),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_beats(cmd_beats), .cmd_burst(cmd_burst), .cmd_size(cmd_size),
    .pe_done(pe_done), .pe_err(pe_err), .abort(abort),
    .busy(busy), .done(done), .err(err)
  );

  always #5 hclk = ~hclk;

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send_desc(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    desc_src = s; desc_dst = d; desc_len = n; desc_valid = 1'b1;
    @(posedge hclk); #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_cmd(output int cyc);
    cyc = 0;
    while (cmd_valid !== 1'b1 && cyc < 50) begin
      @(posedge hclk); #1;
      cyc++;
    end
  endtask

  task automatic accept_cmd();
    cmd_ready = 1'b1;
    @(posedge hclk); #1;
    cmd_ready = 1'b0;
  endtask

  task automatic pe_pulse(input bit is_err, input int gap);
    repeat (gap) begin @(posedge hclk); #1; end
    if (is_err) pe_err = 1'b1;
    else        pe_done = 1'b1;
    @(posedge hclk); #1;
    pe_err = 1'b0; pe_done = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (desc_ready !== 1'b1) begin bad++; $display("FAIL rst_desc_ready got=%b exp=1", desc_ready); end
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_cmd_valid got=%b exp=0", cmd_valid); end
    total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {busy, done, err}); end
    total++; if ({cmd_addr, cmd_write, cmd_beats, cmd_burst} !== 41'd0) begin bad++; $display("FAIL rst_cmd got=%h exp=0", {cmd_addr, cmd_write, cmd_beats, cmd_burst}); end
    total++; if (cmd_size !== 3'd2) begin bad++; $display("FAIL rst_cmd_size got=%0d exp=2", cmd_size); end
  endtask

  task automatic test_single_chunk();
    int c;
    send_desc(32'h0, 32'h1000, 16'd16);
    wait_cmd(c);
    total++; if (c !== 1) begin bad++; $display("FAIL t1_first_latency got=%0d exp=1", c); end
    total++; if ({cmd_addr, cmd_write, cmd_beats, cmd_burst} !== {32'h0, 1'b0, 5'd16, 3'b111}) begin bad++; $display("FAIL t1_rd_cmd got=%h/%b/%0d/%b exp=0/0/16/111", cmd_addr, cmd_write, cmd_beats, cmd_burst); end
    accept_cmd();
    pe_pulse(1'b0, 2);
    wait_cmd(c);
    total++; if (c !== 0) begin bad++; $display("FAIL t1_wr_latency got=%0d exp=0", c); end
    total++; if ({cmd_addr, cmd_write, cmd_beats, cmd_burst} !== {32'h1000, 1'b1, 5'd16, 3'b111}) begin bad++; $display("FAIL t1_wr_cmd got=%h/%b/%0d/%b exp=1000/1/16/111", cmd_addr, cmd_write, cmd_beats, cmd_burst); end
    accept_cmd();
    pe_pulse(1'b0, 1);
    total++; if ({done, err, busy} !== 3'b100) begin bad++; $display("FAIL t1_done got=%b exp=100", {done, err, busy}); end
    @(posedge hclk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL t1_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_boundary();
    int c;
    logic [31:0] ra [2] = '{32'h3F8, 32'h400};
    logic [31:0] wa [2] = '{32'h2000, 32'h2008};
    logic [4:0]  bt [2] = '{5'd2, 5'd4};
    logic [2:0]  rb [2] = '{3'b001, 3'b011};
    logic [2:0]  wb [2] = '{3'b001, 3'b001};
    send_desc(32'h3F8, 32'h2000, 16'd6);
    for (int i = 0; i < 2; i++) begin
      wait_cmd(c);
      total++; if ({cmd_valid, cmd_addr, cmd_write, cmd_beats, cmd_burst} !== {1'b1, ra[i], 1'b0, bt[i], rb[i]}) begin bad++; $display("FAIL t2_rd%0d got=%h/%b/%0d/%b exp=%h/0/%0d/%b", i, cmd_addr, cmd_write, cmd_beats, cmd_burst, ra[i], bt[i], rb[i]); end
      accept_cmd();
      pe_pulse(1'b0, 0);
      wait_cmd(c);
      total++; if ({cmd_valid, cmd_addr, cmd_write, cmd_beats, cmd_burst} !== {1'b1, wa[i], 1'b1, bt[i], wb[i]}) begin bad++; $display("FAIL t2_wr%0d got=%h/%b/%0d/%b exp=%h/1/%0d/%b", i, cmd_addr, cmd_write, cmd_beats, cmd_burst, wa[i], bt[i], wb[i]); end
      accept_cmd();
      pe_pulse(1'b0, 0);
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL t2_done got=%b exp=1", done); end
  endtask

  task automatic test_long_stall();
    int c;
    logic [31:0] ra [3] = '{32'h4000, 32'h4040, 32'h4080};
    logic [31:0] wa [3] = '{32'h8000, 32'h8040, 32'h8080};
    logic [4:0]  bt [3] = '{5'd16, 5'd16, 5'd8};
    logic [2:0]  bb [3] = '{3'b111, 3'b111, 3'b101};
    send_desc(32'h4000, 32'h8000, 16'd40);
    for (int i = 0; i < 3; i++) begin
      wait_cmd(c);
      total++; if (c !== 1) begin bad++; $display("FAIL t3_rd_latency%0d got=%0d exp=1", i, c); end
      total++; if ({cmd_addr, cmd_write, cmd_beats, cmd_burst} !== {ra[i], 1'b0, bt[i], bb[i]}) begin bad++; $display("FAIL t3_rd%0d got=%h/%b/%0d/%b exp=%h/0/%0d/%b", i, cmd_addr, cmd_write, cmd_beats, cmd_burst, ra[i], bt[i], bb[i]); end
      if (i == 0) begin
        for (int s = 0; s < 5; s++) begin
          @(posedge hclk); #1;
          total++; if ({cmd_valid, cmd_addr, cmd_write, cmd_beats, cmd_burst} !== {1'b1, ra[0], 1'b0, bt[0], bb[0]}) begin bad++; $display("FAIL t3_stall%0d got=%b/%h/%0d/%b", s, cmd_valid, cmd_addr, cmd_beats, cmd_burst); end
        end
      end
      accept_cmd();
      pe_pulse(1'b0, 1);
      wait_cmd(c);
      total++; if ({cmd_valid, cmd_addr, cmd_write, cmd_beats, cmd_burst} !== {1'b1, wa[i], 1'b1, bt[i], bb[i]}) begin bad++; $display("FAIL t3_wr%0d got=%h/%b/%0d/%b exp=%h/1/%0d/%b", i, cmd_addr, cmd_write, cmd_beats, cmd_burst, wa[i], bt[i], bb[i]); end
      accept_cmd();
      pe_pulse(1'b0, 1);
    end
    total++; if ({done, busy} !== 2'b10) begin bad++; $display("FAIL t3_done got=%b exp=10", {done, busy}); end
  endtask

  task automatic test_bus_error();
    int c;
    bit seen = 1'b0;
    send_desc(32'h100, 32'h3000, 16'd32);
    wait_cmd(c); accept_cmd(); pe_pulse(1'b0, 0);
    wait_cmd(c); accept_cmd(); pe_pulse(1'b0, 0);
    wait_cmd(c);
    total++; if ({cmd_addr, cmd_write} !== {32'h140, 1'b0}) begin bad++; $display("FAIL t4_rd2 got=%h/%b exp=140/0", cmd_addr, cmd_write); end
    accept_cmd();
    pe_pulse(1'b1, 1);
    total++; if ({err, done, desc_ready, busy} !== 4'b1010) begin bad++; $display("FAIL t4_err got=%b exp=1010", {err, done, desc_ready, busy}); end
    repeat (10) begin @(posedge hclk); #1; if (cmd_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL t4_no_cmd got=%b exp=0", seen); end
  endtask

  task automatic test_abort_wait();
    int c;
    bit seen = 1'b0;
    send_desc(32'h0, 32'h1000, 16'd8);
    wait_cmd(c);
    total++; if ({cmd_beats, cmd_burst} !== {5'd8, 3'b101}) begin bad++; $display("FAIL t5_rd got=%0d/%b exp=8/101", cmd_beats, cmd_burst); end
    accept_cmd();
    abort = 1'b1;
    repeat (3) begin @(posedge hclk); #1; end
    total++; if ({busy, err, cmd_valid} !== 3'b100) begin bad++; $display("FAIL t5_hold got=%b exp=100", {busy, err, cmd_valid}); end
    pe_pulse(1'b0, 0);
    total++; if ({err, done, busy} !== 3'b100) begin bad++; $display("FAIL t5_err got=%b exp=100", {err, done, busy}); end
    abort = 1'b0;
    repeat (10) begin @(posedge hclk); #1; if (cmd_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL t5_no_wr got=%b exp=0", seen); end
  endtask

  task automatic test_abort_cmd();
    int c;
    send_desc(32'h0, 32'h1000, 16'd4);
    wait_cmd(c);
    abort = 1'b1;
    @(posedge hclk); #1;
    total++; if ({cmd_valid, err, busy} !== 3'b010) begin bad++; $display("FAIL abort_cmd got=%b exp=010", {cmd_valid, err, busy}); end
    abort = 1'b0;
    @(posedge hclk); #1;
  endtask

  task automatic test_reject_and_reset();
    int c;
    send_desc(32'h0, 32'h1000, 16'd0);
    total++; if ({err, busy, cmd_valid, desc_ready} !== 4'b1001) begin bad++; $display("FAIL t6_len0 got=%b exp=1001", {err, busy, cmd_valid, desc_ready}); end
    @(posedge hclk); #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL t6_err_pulse got=%b exp=0", err); end
    send_desc(32'h2, 32'h1000, 16'd4);
    total++; if ({err, busy} !== 2'b10) begin bad++; $display("FAIL t6_misalign got=%b exp=10", {err, busy}); end
    send_desc(32'h0, 32'h1000, 16'd16);
    wait_cmd(c); accept_cmd(); pe_pulse(1'b0, 0);
    total++; if ({cmd_valid, cmd_write} !== 2'b11) begin bad++; $display("FAIL t6_in_wr_cmd got=%b exp=11", {cmd_valid, cmd_write}); end
    #2 hresetn = 1'b0;
    #1;
    total++; if ({cmd_valid, desc_ready, busy, done, err} !== 5'b01000) begin bad++; $display("FAIL t6_rst_flags got=%b exp=01000", {cmd_valid, desc_ready, busy, done, err}); end
    total++; if ({cmd_addr, cmd_write, cmd_beats, cmd_burst, cmd_size} !== {32'h0, 1'b0, 5'd0, 3'd0, 3'd2}) begin bad++; $display("FAIL t6_rst_cmd got=%h/%b/%0d/%b/%0d", cmd_addr, cmd_write, cmd_beats, cmd_burst, cmd_size); end
    @(negedge hclk); hresetn = 1'b1;
    @(posedge hclk); #1;
  endtask

  task automatic test_back_to_back();
    int c;
    logic [31:0] ra [2] = '{32'h3FC, 32'h400};
    logic [31:0] wa [2] = '{32'h5000, 32'h5004};
    logic [4:0]  bt [2] = '{5'd1, 5'd2};
    logic [2:0]  bb [2] = '{3'b000, 3'b001};
    send_desc(32'h3FC, 32'h5000, 16'd3);
    for (int i = 0; i < 2; i++) begin
      wait_cmd(c);
      total++; if ({cmd_valid, cmd_addr, cmd_beats, cmd_burst} !== {1'b1, ra[i], bt[i], bb[i]}) begin bad++; $display("FAIL b2b_rd%0d got=%h/%0d/%b exp=%h/%0d/%b", i, cmd_addr, cmd_beats, cmd_burst, ra[i], bt[i], bb[i]); end
      accept_cmd(); pe_pulse(1'b0, 0);
      wait_cmd(c);
      total++; if ({cmd_valid, cmd_addr, cmd_beats, cmd_burst} !== {1'b1, wa[i], bt[i], bb[i]}) begin bad++; $display("FAIL b2b_wr%0d got=%h/%0d/%b exp=%h/%0d/%b", i, cmd_addr, cmd_beats, cmd_burst, wa[i], bt[i], bb[i]); end
      accept_cmd(); pe_pulse(1'b0, 0);
    end
    total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL b2b_done got=%b exp=10", {done, err}); end
    send_desc(32'h10, 32'h20, 16'd4);
    wait_cmd(c);
    total++; if ({cmd_addr, cmd_beats, cmd_burst} !== {32'h10, 5'd4, 3'b011}) begin bad++; $display("FAIL b2b_incr4 got=%h/%0d/%b exp=10/4/011", cmd_addr, cmd_beats, cmd_burst); end
    accept_cmd(); pe_pulse(1'b0, 0);
    wait_cmd(c); accept_cmd(); pe_pulse(1'b0, 0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b exp=1", done); end
  endtask

  initial begin
    hresetn = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    test_reset();
    hresetn = 1'b1;
    @(posedge hclk); #1;
    test_single_chunk();
    test_boundary();
    test_long_stall();
    test_bus_error();
    test_abort_wait();
    test_abort_cmd();
    test_reject_and_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
